// File: rtl/ms_latch_q.sv
// ---------------------------------------------------------------------------
// ms_latch_q -- depth-configurable capture queue for the ms span path.
//
// This block replaces the single-entry level latch that sat between the
// span setup stage and the memory request stage. Bursts of span words are
// queued in order instead of overwriting each other. The block tracks
// occupancy and keeps a sticky flag for words dropped while full. In the
// optional bypass mode, an empty queue passes d straight to q, which
// matches the transparency of the old latch.
//
// Parameters:
//   size     data width in bits
//   depth    number of storage entries (>= 2, any value)
//   ptr_bits pointer width, 2**ptr_bits >= depth
//   bypass   1 = empty-queue flow-through, 0 = strictly registered
//
// Ports:
//   clk      rising-edge clock for all state
//   reset    synchronous, active-high; clears pointers, count and ovf
//   e        push request / capture enable
//   d        word to capture
//   rd       pop request from the consumer
//   clr_ovf  clears the sticky overflow flag
//   q        head-of-queue word (d on flow-through, 0 when empty)
//   valid    q carries a real word
//   full     occupancy equals depth
//   count    occupancy, 0..depth
//   ovf      sticky: a push was dropped while full
// ---------------------------------------------------------------------------
module ms_latch_q #(
    parameter int size     = 8,
    parameter int depth    = 4,
    parameter int ptr_bits = 2,
    parameter int bypass   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                e,
    input  logic [size-1:0]     d,
    input  logic                rd,
    input  logic                clr_ovf,
    output logic [size-1:0]     q,
    output logic                valid,
    output logic                full,
    output logic [ptr_bits:0]   count,
    output logic                ovf
);

    localparam int                  CNT_W   = ptr_bits + 1;
    localparam logic [ptr_bits:0]   DEPTH_C = CNT_W'(depth);
    localparam logic [ptr_bits-1:0] LAST_C  = ptr_bits'(depth - 1);
    localparam logic                BYP_C   = (bypass != 0);

    logic [size-1:0]     mem_q [depth];
    logic [ptr_bits-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_bits-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_bits:0]   count_q, count_d;
    logic                ovf_q, ovf_d;

    logic empty;
    logic flow;
    logic thru;
    logic pop;
    logic push;
    logic do_push;
    logic do_pop;
    logic drop;

    // Handshake decode and outputs, all derived from current state and inputs.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DEPTH_C);
        // Flow-through is only possible while nothing is queued.
        flow  = BYP_C && empty && e;
        valid = !empty || flow;
        pop   = rd && valid;
        thru  = flow && rd;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push  = e && (!full || pop);
        // A word consumed on flow-through never touches storage or pointers.
        do_push = push && !thru;
        do_pop  = pop && !thru;
        drop    = e && full && !pop;

        if (!empty) begin
            q = mem_q[rd_ptr_q];
        end else if (BYP_C) begin
            q = d;
        end else begin
            q = '0;
        end

        count = count_q;
        ovf   = ovf_q;
    end

    // Next-state: pointers wrap at depth-1 explicitly so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set beats clear when both happen in one cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state: reset has priority over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; a push in a reset cycle is suppressed so nothing is recorded.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

endmodule

// File: doc/ms_latch_q.md
Name: ms_latch_q

Overview:
Clocked, parametrised successor to the single-entry level latch in the ms span path. It is a depth-configurable capture queue with occupancy tracking, a pop handshake and a sticky overflow flag. Optional bypass mode reproduces the latch's transparency when the queue is empty. It sits between the ms span setup stage and the memory request stage, absorbing bursts of span words that the single latch would overwrite.

Parameters:
size, 8, data width in bits
depth, 4, number of storage entries (>=2; power of two not required)
ptr_bits, 2, pointer width; must satisfy 2**ptr_bits >= depth
bypass, 0, 1 = empty-queue flow-through (q follows d combinationally), 0 = strictly registered

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
e  input  1  capture enable / push request (successor of the latch enable)
d  input  size  data to capture
rd  input  1  pop request from consumer
clr_ovf  input  1  clears sticky overflow flag
q  output  size  head-of-queue data
valid  output  1  q holds a valid word
full  output  1  count == depth
count  output  ptr_bits+1  current occupancy, 0..depth
ovf  output  1  sticky: a push was dropped while full

Behaviour:
- Reset (reset=1 at the edge): wr_ptr=0, rd_ptr=0, count=0, ovf=0. Storage contents are not cleared.
- Reset takes priority over every other input in the same cycle.
- After reset: valid=0, full=0, q=0 (bypass=0), or q=d with valid=e (bypass=1).
- Combinational outputs from state:
  - full = (count==depth).
  - valid = (count!=0), or (bypass && count==0 && e).
  - q = mem[rd_ptr] when count!=0; d when bypass && count==0; otherwise 0.
- Push accepted: push = e && (!full || pop).
  - Writes d into mem[wr_ptr]; wr_ptr advances.
- Pop accepted: pop = rd && valid.
  - rd_ptr advances, except on a bypass flow-through.
  - rd with valid=0 is ignored; no state change.
- Pointer wrap: a pointer equal to depth-1 advances to 0. Explicit compare, not modulo 2**ptr_bits.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop.
  - Never exceeds depth; never goes below 0.
- Simultaneous push+pop while full: allowed. The head is consumed, the new word is written into the freed slot, count stays depth, and both pointers advance.
- Empty with e=1 and rd=1, bypass=1: flow-through. q=d and valid=1 in the same cycle; the word is consumed; no pointer or count change.
- Empty with e=1 and rd=1, bypass=0: pop ignored (valid=0); push accepted; count -> 1. The word appears on q the next cycle.
- Latency, bypass=0: a word pushed into an empty queue reaches q one cycle after the capture edge.
- Latency, bypass=1: zero cycles while empty; one cycle otherwise.
- Overflow: e=1, full=1, rd=0 -> d is dropped, no state change except ovf <= 1.
- ovf holds until clr_ovf=1 at an edge. If an overflow and clr_ovf occur in the same cycle, set wins (ovf stays 1).
- Ordering: strict FIFO; words leave in push order.
- Reset mid-operation: queued words are discarded (count=0 next cycle). An in-flight push in the reset cycle is not recorded.

Test Plan:
- Reset, then depth=4, bypass=0: push 0x11,0x22,0x33 on consecutive cycles with rd=0 -> count 1,2,3; q=0x11 one cycle after the first push; valid=1; full=0.
- Fill to 4 (0xA0..0xA3), then push 0xA4 with rd=0 -> full=1, ovf=1, count=4. Pop 4 times -> q sequence 0xA0,0xA1,0xA2,0xA3; 0xA4 never appears.
- Full queue, push 0x55 with rd=1 the same cycle -> q advances from 0xA0 to 0xA1, count stays 4. 0x55 emerges after three more pops.
- bypass=1, empty, e=1, d=0x7E, rd=1 -> q=0x7E and valid=1 combinationally; count stays 0 next cycle. Same stimulus with bypass=0 -> valid=0 that cycle, count=1 next cycle, q=0x7E.
- ovf=1 with clr_ovf=1 and an overflow in the same cycle -> ovf stays 1. Next cycle clr_ovf=1, no overflow -> ovf=0.
- depth=3, ptr_bits=2: 10 push/pop pairs with distinct data -> pointers wrap 2->0, FIFO order preserved. Assert reset at count=2 -> count=0, valid=0, q=0 on the following cycle.
